mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  operand A / dividend, driven from register-file read port 1.
REQ-007 b  input  32  operand B / divisor, driven from register-file read port 2.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle registered pulse when hi/lo update.
REQ-010 hi  output  32  HI result register: product[63:32] or remainder.
REQ-011 lo  output  32  LO result register: product[31:0] or quotient.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-013 IDLE with start=1 at edge N: latch a, b and op (sign-converted to magnitudes for signed ops); go to CALC; clear counter; busy=1 after edge N.
REQ-014 CALC: one radix-2 step per cycle (shift-add for multiply, restoring subtract-shift for divide); 32 steps; the edge completing step 32 (edge N+32) SHALL move to FIX.
REQ-015 FIX at edge N+33: apply sign correction; write hi/lo; assert done for exactly the following cycle; return to IDLE with busy=0.
REQ-016 Latency SHALL be exactly 33 cycles from start sample to hi/lo valid; hi/lo SHALL hold their values at all other times.
REQ-017 start while busy=1 SHALL be ignored; operand changes after edge N SHALL NOT affect the result.
REQ-018 Multiply: {hi,lo} = full 64-bit product; MULT treats operands as two's complement; MULTU as unsigned.
REQ-019 Divide: quotient truncates toward zero; remainder sign follows dividend; |remainder| < |divisor|.
REQ-020 Divide by zero (DIV or DIVU): lo = 32'hFFFFFFFF, hi = a; latency unchanged.
REQ-021 DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-022 start asserted in the same cycle done is high SHALL be accepted (FSM is already in IDLE).

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-024 Reset mid-operation SHALL abort the operation; no done pulse for it SHALL ever appear.
REQ-025 The first start after reset deasserts SHALL run normally with full 33-cycle latency.

Configuration
REQ-026 Macro MUL_DIV_SIGNED_EN: when defined, MULT and DIV SHALL behave as signed per REQ-018..REQ-021.
REQ-027 When MUL_DIV_SIGNED_EN is undefined: op[0] SHALL be ignored; all operations unsigned; sign-conversion and FIX correction logic absent; FIX state retained so latency stays 33 cycles.

Verification
REQ-028 MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 cycles hi=FFFFFFFE lo=00000001, done one cycle.
REQ-029 MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; without macro -> hi=00000004 lo=FFFFFFF1.
REQ-030 DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU a=00000064 b=0 -> lo=FFFFFFFF hi=00000064.
REQ-031 Start MULTU 3*4, pulse start again with new operands at cycle 5 -> ignored; hi=0 lo=0000000C at cycle 33.
REQ-032 Start DIVU 100/7, assert reset at cycle 10 -> busy=0, hi=lo=0 immediately; no done pulse within 40 cycles.
REQ-033 Back-to-back: start MULTU 2*3, re-assert start during the done cycle with DIVU 9/4 -> lo=6 hi=0, then lo=2 hi=1 exactly 33 cycles later.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one radix-2 step per cycle, 33-cycle latency.
// Signed MULT/DIV are enabled by defining MUL_DIV_SIGNED_EN; otherwise every op is unsigned.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        div0_q, div0_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] res_hi, res_lo;

`ifdef MUL_DIV_SIGNED_EN
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        sa, sb;
    logic [63:0] prod_neg;
`else
    logic        unused_op0;
    assign unused_op0 = op[0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, mcand_q};
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift - {1'b0, mcand_q};
        res_hi    = acc_hi_q;
        res_lo    = acc_lo_q;
`ifdef MUL_DIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        sa        = op[0] & a[31];
        sb        = op[0] & b[31];
        a_mag     = sa ? (~a + 32'd1) : a;
        b_mag     = sb ? (~b + 32'd1) : b;
        prod_neg  = ~{acc_hi_q, acc_lo_q} + 64'd1;
`else
        a_mag     = a;
        b_mag     = b;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = 5'd0;
                    is_div_d = op[1];
                    div0_d   = (b == 32'd0);
                    mcand_d  = b_mag;
                    acc_hi_d = 32'd0;
                    acc_lo_d = a_mag;
`ifdef MUL_DIV_SIGNED_EN
                    neg_res_d = sa ^ sb;
                    neg_rem_d = sa;
`endif
                end
            end
            S_CALC: begin
                // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
                if (is_div_q) begin
                    if (div_ge) begin
                        acc_hi_d = div_diff[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    if (acc_lo_q[0]) begin
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
                    end else begin
                        {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
`ifdef MUL_DIV_SIGNED_EN
                if (is_div_q) begin
                    res_lo = neg_res_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                    res_hi = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                end else if (neg_res_q) begin
                    {res_hi, res_lo} = prod_neg;
                end
`endif
                // The remainder already equals the dividend here; only the quotient needs forcing.
                if (is_div_q && div0_q) begin
                    res_lo = 32'hFFFF_FFFF;
                end
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            mcand_q  <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MUL_DIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule
